pc_fetch_sequencer: RTL and testbench

//  Owns the 16-bit program counter and sequences instruction fetch for the core.

---
 rtl/pc_fetch_sequencer_pkg.sv | 20 ++
 rtl/pc_fetch_sequencer_pc_incr2.sv | 11 +
 rtl/pc_fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch sequencer.
package pc_fetch_sequencer_pkg;

    localparam int PC_W        = 16;
    localparam int INSTR_BYTES = 2;
    localparam int TO_W        = 8;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        FETCH  = 2'b01,
        ISSUE  = 2'b10,
        HALTED = 2'b11
    } fetch_state_t;

    // Instructions are halfword aligned, so a loaded target always has bit0 cleared.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_incr2.sv
// Sequential-path incrementer: advances the PC by one instruction, wrapping modulo 2^16.
module pc_incr2
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_inc
);

    assign pc_inc = pc_cur + 16'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch sequencer: FETCH -> ISSUE -> PC update, with
// sticky misalign / fetch-timeout flags and a terminal HALTED state.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        issue_ack,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        halt,
    output logic [15:0] pc,
    output logic        misalign,
    output logic        fetch_err
);

    fetch_state_t    state_r, state_nxt_s;
    logic [PC_W-1:0] pc_r, pc_nxt_s, pc_inc_s;
    logic [15:0]     ir_r, ir_nxt_s;
    logic            ir_valid_r, fetch_req_r;
    logic            misalign_r, misalign_nxt_s;
    logic            fetch_err_r, fetch_err_nxt_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
    logic [PC_W-1:0] target_s;
    logic            target_take_s;

    pc_incr2 u_pc_incr2 (
        .pc_cur (pc_r),
        .pc_inc (pc_inc_s)
    );

    // Redirect selection: jump outranks a taken branch.
    always_comb begin
        target_s      = 16'h0000;
        target_take_s = 1'b0;
        if (jump) begin
            target_s      = jump_target;
            target_take_s = 1'b1;
        end else if (branch_taken) begin
            target_s      = branch_target;
            target_take_s = 1'b1;
        end else begin
            target_s      = 16'h0000;
            target_take_s = 1'b0;
        end
    end

    // Next-state and next-value logic for the fetch sequence.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        ir_nxt_s        = ir_r;
        misalign_nxt_s  = misalign_r;
        fetch_err_nxt_s = fetch_err_r;
        to_cnt_nxt_s    = to_cnt_r;
        case (state_r)
            BOOT: begin
                state_nxt_s  = FETCH;
                to_cnt_nxt_s = 8'd0;
            end
            FETCH: begin
                if (mem_ready) begin
                    ir_nxt_s    = mem_data;
                    state_nxt_s = ISSUE;
                end else if (to_cnt_r == (TIMEOUT - 8'd1)) begin
                    fetch_err_nxt_s = 1'b1;
                    state_nxt_s     = HALTED;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + 8'd1;
                end
            end
            ISSUE: begin
                if (issue_ack) begin
                    if (target_take_s) begin
                        pc_nxt_s       = align_pc(target_s);
                        misalign_nxt_s = misalign_r | target_s[0];
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                    to_cnt_nxt_s = 8'd0;
                    state_nxt_s  = halt ? HALTED : FETCH;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // State and output registers; handshake outputs follow the state being entered.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r     <= BOOT;
            pc_r        <= RESET_VEC;
            ir_r        <= 16'h0000;
            ir_valid_r  <= 1'b0;
            fetch_req_r <= 1'b0;
            misalign_r  <= 1'b0;
            fetch_err_r <= 1'b0;
            to_cnt_r    <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            ir_valid_r  <= (state_nxt_s == ISSUE);
            fetch_req_r <= (state_nxt_s == FETCH);
            misalign_r  <= misalign_nxt_s;
            fetch_err_r <= fetch_err_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
        end
    end

    assign fetch_req  = fetch_req_r;
    assign fetch_addr = pc_r;
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign ir_valid   = ir_valid_r;
    assign misalign   = misalign_r;
    assign fetch_err  = fetch_err_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a scoreboard of expected fetch
// addresses and instruction words.
module tb_pc_fetch_sequencer;

    logic        CLK;
    logic        Reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic        issue_ack;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        halt;
    logic [15:0] pc;
    logic        misalign;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] addr_q[$];
    logic [15:0] ir_q[$];

    pc_fetch_sequencer dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .issue_ack     (issue_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .misalign      (misalign),
        .fetch_err     (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        @(negedge CLK);
        chk("rst_fetch_req", {15'd0, fetch_req}, 16'd0);
        chk("rst_ir_valid",  {15'd0, ir_valid},  16'd0);
        chk("rst_pc",        pc,                 16'h0000);
        chk("rst_ir",        ir,                 16'h0000);
        chk("rst_misalign",  {15'd0, misalign},  16'd0);
        chk("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
        Reset = 1'b0;
    endtask

    // Wait for a fetch, check its address against the scoreboard, return a word.
    task automatic do_fetch(input logic [15:0] word);
        logic [15:0] exp_addr;
        logic [15:0] exp_ir;
        int n;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("fetch_req_seen", {15'd0, fetch_req}, 16'd1);
        chk("addr_q_size", 16'(addr_q.size()), 16'd1);
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 16'hxxxx;
        chk("fetch_addr", fetch_addr, exp_addr);
        chk("ir_valid_in_fetch", {15'd0, ir_valid}, 16'd0);
        mem_ready = 1'b1;
        mem_data  = word;
        ir_q.push_back(word);
        @(negedge CLK);
        mem_ready = 1'b0;
        mem_data  = 16'hDEAD;
        chk("ir_valid_rise", {15'd0, ir_valid}, 16'd1);
        chk("fetch_req_drop", {15'd0, fetch_req}, 16'd0);
        exp_ir = (ir_q.size() > 0) ? ir_q.pop_front() : 16'hxxxx;
        chk("ir_word", ir, exp_ir);
        chk("pc_hold", pc, exp_addr);
    endtask

    // Acknowledge the instruction in ir; exp_next is the address the next fetch must use.
    task automatic do_issue(input logic j, input logic [15:0] jt, input logic b,
                            input logic [15:0] bt, input logic h, input logic [15:0] exp_next);
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt; halt = h;
        issue_ack = 1'b1;
        if (!h) addr_q.push_back(exp_next);
        @(negedge CLK);
        issue_ack = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
        jump_target = 16'h0000; branch_target = 16'h0000;
        chk("ir_valid_after_ack", {15'd0, ir_valid}, 16'd0);
        chk("pc_after_ack", pc, exp_next);
    endtask

    initial begin
        Reset = 1'b1; mem_ready = 1'b0; mem_data = 16'h0000; issue_ack = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000; jump = 1'b0;
        jump_target = 16'h0000; halt = 1'b0;
        @(negedge CLK);
        apply_reset();
        addr_q.push_back(16'h0000);

        // sequential fetches
        do_fetch(16'hA001);
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002);
        do_fetch(16'hB002);
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004);
        do_fetch(16'hC003);

        // wrap from FFFE
        do_issue(1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'hFFFE);
        do_fetch(16'hD004);
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        do_fetch(16'hE005);
        chk("wrap_misalign", {15'd0, misalign}, 16'd0);
        chk("wrap_fetch_err", {15'd0, fetch_err}, 16'd0);

        // jump outranks branch
        do_issue(1'b1, 16'h1234, 1'b1, 16'h0800, 1'b0, 16'h1234);
        do_fetch(16'hF006);
        chk("jump_wins_misalign", {15'd0, misalign}, 16'd0);

        // odd branch target: aligned and sticky misalign
        do_issue(1'b0, 16'h0000, 1'b1, 16'h0801, 1'b0, 16'h0800);
        do_fetch(16'h1007);
        chk("misalign_set", {15'd0, misalign}, 16'd1);
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0802);
        do_fetch(16'h2008);
        chk("misalign_sticky", {15'd0, misalign}, 16'd1);

        // stall 10 cycles; stray mem_ready and halt without ack have no effect
        mem_ready = 1'b1; mem_data = 16'h5555; halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("stall_ir", ir, 16'h2008);
            chk("stall_pc", pc, 16'h0802);
            chk("stall_ir_valid", {15'd0, ir_valid}, 16'd1);
            chk("stall_fetch_req", {15'd0, fetch_req}, 16'd0);
        end
        mem_ready = 1'b0; halt = 1'b0;

        // halt on ack: no further requests
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0804);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("halted_fetch_req", {15'd0, fetch_req}, 16'd0);
            chk("halted_pc", pc, 16'h0804);
            chk("halted_ir", ir, 16'h2008);
        end
        mem_ready = 1'b0;

        // fetch timeout
        apply_reset();
        @(negedge CLK);
        chk("to_fetch_req", {15'd0, fetch_req}, 16'd1);
        for (int i = 1; i < 255; i++) @(negedge CLK);
        chk("to_not_yet", {15'd0, fetch_err}, 16'd0);
        chk("to_still_req", {15'd0, fetch_req}, 16'd1);
        @(negedge CLK);
        chk("to_fetch_err", {15'd0, fetch_err}, 16'd1);
        chk("to_req_drop", {15'd0, fetch_req}, 16'd0);

        // reset from HALTED, then reset again mid-FETCH with a stray issue_ack
        apply_reset();
        @(negedge CLK);
        issue_ack = 1'b1; jump = 1'b1; jump_target = 16'h4444;
        @(negedge CLK);
        chk("stray_ack_pc", pc, 16'h0000);
        chk("stray_ack_req", {15'd0, fetch_req}, 16'd1);
        issue_ack = 1'b0; jump = 1'b0; jump_target = 16'h0000;
        apply_reset();
        addr_q.delete();
        ir_q.delete();
        addr_q.push_back(16'h0000);
        do_fetch(16'h7777);
        do_issue(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002);
        do_fetch(16'h8888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
